pe_input_scheduler: RTL and testbench
=====================================

// Module: pe_input_scheduler
// PURPOSE
//  Input scheduler in front of the PE MUL->ACC->AF pipeline. Arbitrates N_PORTS NoC ejection ports
//  round-robin into the single datapath. Passes configuration packets through and admits DATA packets
//  only for the layer sequence currently being accumulated, so the accumulator never sees interleaved layers.
// PARAMETERS
//  NETWORK_SIZE  256  neurons in network; SRC/DEST width SW=$clog2(NETWORK_SIZE)
//  N_PORTS       4    number of requesting input ports
//  (local) PAYLOAD_WIDTH=32, SEQ_WIDTH=$clog2($sqrt(NETWORK_SIZE)*2), TYPE_WIDTH=3, PACKET_SIZE=3+SEQ_WIDTH+2*SW+32
//  Packet fields, LSB first: payload[31:0], source[SW], dest[SW], seq[SEQ_WIDTH], type[3]
// PORTS
//  clk             in   1                  clock
//  rst             in   1                  synchronous, active-high reset
//  in_valid        in   N_PORTS            per-port packet valid
//  in_packet       in   N_PORTS*PACKET_SIZE port i in bits [i*PACKET_SIZE +: PACKET_SIZE]
//  in_halt         out  N_PORTS            per-port halt; sender holds packet while valid&halt
//  SCH_MUL_valid   out  1                  packet valid to multiplier
//  SCH_MUL_type    out  3                  packet type
//  SCH_MUL_seqNum  out  SEQ_WIDTH          packet sequence number
//  SCH_MUL_inputNum out SW                 source field (weight index / CONF_INB input count)
//  SCH_MUL_data    out  32                 payload
//  SCH_MUL_halt    in   1                  multiplier back-pressure
//  exp_seq         out  SEQ_WIDTH          sequence currently admitted
//  layer_done      out  1                  1-cycle pulse: last input of a layer accepted
// BEHAVIOUR
//  Types: DATA=3'b000, CONF_INB=3'b001, CONF_W=3'b010, CONF_AFLUT=3'b100, CONF_AFLB=3'b101, CONF_AFUB=3'b110.
//  Reset: SCH_MUL_valid=0, SCH_MUL_type/seqNum/inputNum/data=0, in_halt=all 1, exp_seq=0, layer_done=0,
//   state=UNCONF, in_cnt=0, num_inputs=0, rr_ptr=0. Reset mid-packet discards the output register content.
//  Output register (1 entry): load = !SCH_MUL_valid | !SCH_MUL_halt. Latency grant->SCH_MUL_valid = 1 cycle.
//   Register holds all fields stable while SCH_MUL_valid&SCH_MUL_halt.
//  Eligibility of port i (in_valid[i]=1):
//   CONF_W/CONF_AF*: always. CONF_INB: only when in_cnt==0 (layer boundary).
//   DATA: only in RUN and seq==exp_seq. Other DATA held (in_halt[i]=1), never granted.
//  Arbitration: one grant per cycle when load=1; first eligible port at/after rr_ptr (mod N_PORTS);
//   on grant, rr_ptr<=granted+1 (wraps N_PORTS-1->0). in_halt[i]=!(grant[i]&load). No eligible port: load
//   with SCH_MUL_valid=0.
//  States: UNCONF -> RUN on accepted CONF_INB with source!=0 (num_inputs<=source). CONF_INB with source==0:
//   forwarded, num_inputs<=0, state<=UNCONF. RUN: CONF_INB accepted at boundary updates num_inputs.
//  Accepted DATA: if in_cnt+1==num_inputs: in_cnt<=0, exp_seq<=exp_seq+1 (wraps 2^SEQ_WIDTH-1->0),
//   layer_done=1 next cycle; else in_cnt<=in_cnt+1. in_cnt width SW+1 (num_inputs=NETWORK_SIZE legal... capped SW).
//  Simultaneous eligible CONF and DATA on different ports: pure round-robin, no type priority.
// CONFIGURATION
//  Macro SCH_DROP_STALE_EN:
//   defined: DATA with seq==exp_seq-1 (mod 2^SEQ_WIDTH) is stale; consumed (in_halt=0, one per cycle,
//    via same RR grant, does not use output register slot, not forwarded); extra port
//    drop_cnt out 8: stale drops, saturates at 255, reset 0.
//   undefined: stale DATA treated as any mismatched seq (held); no drop_cnt port.
// TESTING
//  T1 reset: rst 2 cycles with all in_valid=1 -> in_halt=4'hF, SCH_MUL_valid=0, exp_seq=0.
//  T2 config: port0 CONF_INB source=3 data=bias 100 -> forwarded 1 cycle later, state RUN; then 3 DATA
//   seq0 on ports 1,2,3 same cycle -> granted 1,2,3 in successive cycles, layer_done after third, exp_seq=1.
//  T3 sequencing: DATA seq1 on port2 while exp_seq=0, in_cnt=0 -> held (in_halt[2]=1) until 3 seq0 accepted.
//  T4 back-pressure: SCH_MUL_halt=1 for 5 cycles with valid output -> fields stable, all in_halt=1; release
//   -> next grant same cycle.
//  T5 wrap: 2^SEQ_WIDTH layers of 1 input -> exp_seq wraps to 0, rr_ptr wraps N_PORTS-1->0.
//  T6 SCH_DROP_STALE_EN: exp_seq=1, DATA seq0 on port1 -> consumed, not forwarded, drop_cnt=1.

Source files
------------

// File: rtl/pe_input_scheduler.sv
// Round-robin input scheduler in front of the PE MUL->ACC->AF pipeline; admits DATA only for the active layer.
// Build macro SCH_DROP_STALE_EN: consume DATA one sequence behind exp_seq and count the drops on drop_cnt.

package pe_input_scheduler_pkg;

    typedef enum logic [2:0] {
        T_DATA       = 3'b000,
        T_CONF_INB   = 3'b001,
        T_CONF_W     = 3'b010,
        T_CONF_AFLUT = 3'b100,
        T_CONF_AFLB  = 3'b101,
        T_CONF_AFUB  = 3'b110
    } pkt_type_e;

    // Smallest w with 2^w >= 2*sqrt(n), evaluated exactly as 4^w >= 4*n.
    function automatic int f_seq_width(input int n);
        int w;
        w = 0;
        while ((longint'(1) << (2 * w)) < (longint'(4) * longint'(n)))
            w++;
        return w;
    endfunction

endpackage

module pe_input_scheduler
    import pe_input_scheduler_pkg::*;
#(
    parameter  int NETWORK_SIZE  = 256,
    parameter  int N_PORTS       = 4,
    localparam int SW            = $clog2(NETWORK_SIZE),
    localparam int SEQ_WIDTH     = f_seq_width(NETWORK_SIZE),
    localparam int PAYLOAD_WIDTH = 32,
    localparam int TYPE_WIDTH    = 3,
    localparam int PACKET_SIZE   = TYPE_WIDTH + SEQ_WIDTH + 2 * SW + PAYLOAD_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_PORTS-1:0]             in_valid,
    input  logic [N_PORTS*PACKET_SIZE-1:0] in_packet,
    output logic [N_PORTS-1:0]             in_halt,
    output logic                           SCH_MUL_valid,
    output logic [TYPE_WIDTH-1:0]          SCH_MUL_type,
    output logic [SEQ_WIDTH-1:0]           SCH_MUL_seqNum,
    output logic [SW-1:0]                  SCH_MUL_inputNum,
    output logic [PAYLOAD_WIDTH-1:0]       SCH_MUL_data,
    input  logic                           SCH_MUL_halt,
    output logic [SEQ_WIDTH-1:0]           exp_seq,
    output logic                           layer_done
`ifdef SCH_DROP_STALE_EN
    ,
    output logic [7:0]                     drop_cnt
`endif
);

    localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef enum logic {
        S_UNCONF = 1'b0,
        S_RUN    = 1'b1
    } state_e;

    state_e                   r_state;
    state_e                   w_state_nxt;
    logic [SEQ_WIDTH-1:0]     r_exp_seq;
    logic [SW:0]              r_in_cnt;
    logic [SW-1:0]            r_num_inputs;
    logic [PTR_W-1:0]         r_rr_ptr;
    logic                     r_layer_done;

    logic                     r_valid;
    logic [TYPE_WIDTH-1:0]    r_type;
    logic [SEQ_WIDTH-1:0]     r_seq;
    logic [SW-1:0]            r_src;
    logic [PAYLOAD_WIDTH-1:0] r_data;

    logic [TYPE_WIDTH-1:0]    w_type [N_PORTS];
    logic [SEQ_WIDTH-1:0]     w_seq  [N_PORTS];
    logic [SW-1:0]            w_src  [N_PORTS];
    logic [PAYLOAD_WIDTH-1:0] w_data [N_PORTS];
    logic [N_PORTS-1:0]       w_unused_dest;

    logic [N_PORTS-1:0]       w_elig;
    logic [N_PORTS-1:0]       w_cand;
    logic                     w_at_boundary;
    logic                     w_load;
    logic                     w_found;
    logic [PTR_W-1:0]         w_gidx;
    logic [PTR_W-1:0]         w_idx;
    logic                     w_accept;
    logic                     w_drop;
    logic                     w_fwd;
    logic                     w_data_acc;
    logic                     w_inb_acc;
    logic [SW:0]              w_cnt_inc;
    logic                     w_layer_end;

    for (genvar g = 0; g < N_PORTS; g++) begin : g_field
        localparam int BASE = g * PACKET_SIZE;
        assign w_data[g]        = in_packet[BASE +: PAYLOAD_WIDTH];
        assign w_src[g]         = in_packet[BASE + PAYLOAD_WIDTH +: SW];
        assign w_unused_dest[g] = ^in_packet[BASE + PAYLOAD_WIDTH + SW +: SW];
        assign w_seq[g]         = in_packet[BASE + PAYLOAD_WIDTH + 2 * SW +: SEQ_WIDTH];
        assign w_type[g]        = in_packet[BASE + PACKET_SIZE - TYPE_WIDTH +: TYPE_WIDTH];
    end

    assign w_at_boundary = (r_in_cnt == '0);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            case (w_type[i])
                T_CONF_W, T_CONF_AFLUT, T_CONF_AFLB, T_CONF_AFUB:
                    w_elig[i] = in_valid[i];
                T_CONF_INB:
                    w_elig[i] = in_valid[i] & w_at_boundary;
                T_DATA:
                    w_elig[i] = in_valid[i] & (r_state == S_RUN) & (w_seq[i] == r_exp_seq);
                default:
                    w_elig[i] = 1'b0;
            endcase
        end
    end

    // Output register slot is free when empty or being drained this cycle.
    assign w_load = ~r_valid | ~SCH_MUL_halt;

    always_comb begin
        w_found = 1'b0;
        w_gidx  = r_rr_ptr;
        w_idx   = r_rr_ptr;
        for (int k = 0; k < N_PORTS; k++) begin
            if (!w_found && w_cand[w_idx]) begin
                w_found = 1'b1;
                w_gidx  = w_idx;
            end
            w_idx = (w_idx == PTR_W'(N_PORTS - 1)) ? '0 : w_idx + PTR_W'(1);
        end
    end

    assign w_accept = w_load & w_found & ~rst;

`ifdef SCH_DROP_STALE_EN
    logic [N_PORTS-1:0] w_stale;
    logic [7:0]         r_drop_cnt;

    always_comb begin
        w_stale = '0;
        for (int i = 0; i < N_PORTS; i++)
            w_stale[i] = in_valid[i] & (w_type[i] == T_DATA)
                       & (w_seq[i] == r_exp_seq - SEQ_WIDTH'(1));
    end

    assign w_cand = w_elig | w_stale;
    assign w_drop = w_accept & w_stale[w_gidx];

    always_ff @(posedge clk) begin
        if (rst)
            r_drop_cnt <= '0;
        else if (w_drop && r_drop_cnt != 8'hFF)
            r_drop_cnt <= r_drop_cnt + 8'd1;
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign w_cand = w_elig;
    assign w_drop = 1'b0;
`endif

    assign w_fwd      = w_accept & ~w_drop;
    assign w_data_acc = w_fwd & (w_type[w_gidx] == T_DATA);
    assign w_inb_acc  = w_fwd & (w_type[w_gidx] == T_CONF_INB);
    assign w_cnt_inc  = r_in_cnt + (SW + 1)'(1);
    assign w_layer_end = (w_cnt_inc == {1'b0, r_num_inputs});

    always_comb begin
        in_halt = '1;
        if (w_accept)
            in_halt[w_gidx] = 1'b0;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_inb_acc)
            w_state_nxt = (w_src[w_gidx] != '0) ? S_RUN : S_UNCONF;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_UNCONF;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_type       <= '0;
            r_seq        <= '0;
            r_src        <= '0;
            r_data       <= '0;
            r_rr_ptr     <= '0;
            r_exp_seq    <= '0;
            r_in_cnt     <= '0;
            r_num_inputs <= '0;
            r_layer_done <= 1'b0;
        end else begin
            r_layer_done <= 1'b0;
            if (w_load) begin
                r_valid <= w_fwd;
                if (w_fwd) begin
                    r_type <= w_type[w_gidx];
                    r_seq  <= w_seq[w_gidx];
                    r_src  <= w_src[w_gidx];
                    r_data <= w_data[w_gidx];
                end
            end
            if (w_accept)
                r_rr_ptr <= (w_gidx == PTR_W'(N_PORTS - 1)) ? '0 : w_gidx + PTR_W'(1);
            if (w_inb_acc)
                r_num_inputs <= w_src[w_gidx];
            if (w_data_acc) begin
                if (w_layer_end) begin
                    r_in_cnt     <= '0;
                    r_exp_seq    <= r_exp_seq + SEQ_WIDTH'(1);
                    r_layer_done <= 1'b1;
                end else begin
                    r_in_cnt <= w_cnt_inc;
                end
            end
        end
    end

    assign SCH_MUL_valid    = r_valid;
    assign SCH_MUL_type     = r_type;
    assign SCH_MUL_seqNum   = r_seq;
    assign SCH_MUL_inputNum = r_src;
    assign SCH_MUL_data     = r_data;
    assign exp_seq          = r_exp_seq;
    assign layer_done       = r_layer_done;

endmodule

// File: tb/tb_pe_input_scheduler.sv
// Randomized bench for pe_input_scheduler: per-port sender queues, a packet-level reference model
// and cycle-by-cycle comparison of halts, the output register, exp_seq, layer_done (and drop_cnt).
module tb_pe_input_scheduler;

    localparam int N    = 4;
    localparam int SW   = 8;
    localparam int SEQW = 5;
    localparam int NSEQ = 32;
    localparam int PS   = 3 + SEQW + 2 * SW + 32;

    localparam logic [2:0] DATA    = 3'b000;
    localparam logic [2:0] INB     = 3'b001;
    localparam logic [2:0] CW      = 3'b010;
    localparam logic [2:0] AFLUT   = 3'b100;
    localparam logic [2:0] AFLB    = 3'b101;
    localparam logic [2:0] AFUB    = 3'b110;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    in_valid;
    logic [N*PS-1:0] in_packet;
    logic [N-1:0]    in_halt;
    logic            SCH_MUL_valid;
    logic [2:0]      SCH_MUL_type;
    logic [SEQW-1:0] SCH_MUL_seqNum;
    logic [SW-1:0]   SCH_MUL_inputNum;
    logic [31:0]     SCH_MUL_data;
    logic            SCH_MUL_halt;
    logic [SEQW-1:0] exp_seq;
    logic            layer_done;
`ifdef SCH_DROP_STALE_EN
    logic [7:0]      drop_cnt;
`endif

    pe_input_scheduler #(.NETWORK_SIZE(256), .N_PORTS(N)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_packet        (in_packet),
        .in_halt          (in_halt),
        .SCH_MUL_valid    (SCH_MUL_valid),
        .SCH_MUL_type     (SCH_MUL_type),
        .SCH_MUL_seqNum   (SCH_MUL_seqNum),
        .SCH_MUL_inputNum (SCH_MUL_inputNum),
        .SCH_MUL_data     (SCH_MUL_data),
        .SCH_MUL_halt     (SCH_MUL_halt),
        .exp_seq          (exp_seq),
        .layer_done       (layer_done)
`ifdef SCH_DROP_STALE_EN
        ,
        .drop_cnt         (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: packet queues per port plus the scheduler's architectural state.
    logic [PS-1:0] port_q [N][$];
    bit            m_run;
    int            m_num, m_cnt, m_exp, m_ptr, m_drop;
    bit            m_valid, m_ld;
    logic [PS-1:0] m_out;
    int            halt_pct;
    bit            halt_force;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [PS-1:0] mk(input logic [2:0] t, input int seq, input int src,
                                         input logic [31:0] d);
        logic [SW-1:0] dest;
        dest = SW'($urandom);
        return {t, SEQW'(seq), dest, SW'(src), d};
    endfunction

    function automatic logic [2:0] f_type(input logic [PS-1:0] p); return p[PS-1 -: 3]; endfunction
    function automatic int f_seq(input logic [PS-1:0] p); return int'(p[32 + 2 * SW +: SEQW]); endfunction
    function automatic int f_src(input logic [PS-1:0] p); return int'(p[32 +: SW]); endfunction

    function automatic bit is_stale(input logic [PS-1:0] p);
`ifdef SCH_DROP_STALE_EN
        return f_type(p) == DATA && f_seq(p) == (m_exp + NSEQ - 1) % NSEQ;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit eligible(input int i);
        logic [PS-1:0] p;
        if (port_q[i].size() == 0) return 1'b0;
        p = port_q[i][0];
        if (is_stale(p)) return 1'b1;
        case (f_type(p))
            CW, AFLUT, AFLB, AFUB: return 1'b1;
            INB:                   return m_cnt == 0;
            DATA:                  return m_run && f_seq(p) == m_exp;
            default:               return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_run = 0; m_num = 0; m_cnt = 0; m_exp = 0; m_ptr = 0; m_drop = 0;
        m_valid = 0; m_ld = 0; m_out = '0;
        for (int i = 0; i < N; i++) port_q[i].delete();
    endtask

    task automatic drive_and_predict();
        logic [N-1:0]  exp_halt;
        logic [PS-1:0] p;
        bit            load;
        int            win;
        for (int i = 0; i < N; i++) begin
            if (port_q[i].size() > 0) begin
                in_valid[i] = 1'b1;
                in_packet[i * PS +: PS] = port_q[i][0];
            end else begin
                in_valid[i] = 1'b0;
                in_packet[i * PS +: PS] = PS'({$urandom, $urandom});
            end
        end
        SCH_MUL_halt = halt_force || ($urandom_range(0, 99) < halt_pct);
        #1;
        load = !m_valid || !SCH_MUL_halt;
        win  = -1;
        for (int k = 0; k < N; k++)
            if (win < 0 && eligible((m_ptr + k) % N)) win = (m_ptr + k) % N;
        exp_halt = '1;
        if (load && win >= 0) exp_halt[win] = 1'b0;
        check("in_halt", 64'(in_halt), 64'(exp_halt));

        m_ld = 0;
        if (load) begin
            if (win < 0) begin
                m_valid = 0;
            end else begin
                p = port_q[win].pop_front();
                m_ptr = (win + 1) % N;
                if (is_stale(p)) begin
                    m_valid = 0;
                    if (m_drop < 255) m_drop++;
                end else begin
                    m_valid = 1;
                    m_out   = p;
                    if (f_type(p) == INB) begin
                        m_num = f_src(p);
                        m_run = (m_num != 0);
                    end else if (f_type(p) == DATA) begin
                        m_cnt++;
                        if (m_cnt == m_num) begin
                            m_cnt = 0;
                            m_exp = (m_exp + 1) % NSEQ;
                            m_ld  = 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_outputs();
        check("valid", 64'(SCH_MUL_valid), 64'(m_valid));
        if (m_valid) begin
            check("type",     64'(SCH_MUL_type),     64'(f_type(m_out)));
            check("seqNum",   64'(SCH_MUL_seqNum),   64'(f_seq(m_out)));
            check("inputNum", 64'(SCH_MUL_inputNum), 64'(f_src(m_out)));
            check("data",     64'(SCH_MUL_data),     64'(m_out[31:0]));
        end
        check("exp_seq",    64'(exp_seq),    64'(m_exp));
        check("layer_done", 64'(layer_done), 64'(m_ld));
`ifdef SCH_DROP_STALE_EN
        check("drop_cnt",   64'(drop_cnt),   64'(m_drop));
`endif
    endtask

    task automatic step();
        drive_and_predict();
        @(negedge clk);
        check_outputs();
    endtask

    function automatic int pending();
        int n;
        n = m_valid ? 1 : 0;
        for (int i = 0; i < N; i++) n += port_q[i].size();
        return n;
    endfunction

    task automatic drain(input int budget);
        int c;
        c = 0;
        halt_force = 0;
        while (pending() != 0 && c < budget) begin
            step();
            c++;
        end
        check("drain_left", 64'(pending()), 64'd0);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        in_valid     = '1;
        in_packet    = {N{PS'({$urandom, $urandom})}};
        SCH_MUL_halt = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_halt", 64'(in_halt),       64'hF);
        check("rst_valid",   64'(SCH_MUL_valid), 64'd0);
        check("rst_exp_seq", 64'(exp_seq),       64'd0);
        check("rst_ldone",   64'(layer_done),    64'd0);
`ifdef SCH_DROP_STALE_EN
        check("rst_drop",    64'(drop_cnt),      64'd0);
`endif
        model_reset();
        rst = 1'b0;
    endtask

    task automatic push_cfg(input int port);
        logic [2:0] t;
        case ($urandom_range(0, 3))
            0:       t = CW;
            1:       t = AFLUT;
            2:       t = AFLB;
            default: t = AFUB;
        endcase
        port_q[port].push_back(mk(t, $urandom, $urandom, $urandom));
    endtask

    task automatic configure(input int port, input int n, input logic [31:0] bias);
        port_q[port].push_back(mk(INB, $urandom, n, bias));
        drain(50);
    endtask

    task automatic gen_layers(input int n, input int layers, input int cfg_pct);
        int base;
        base = m_exp;
        for (int l = 0; l < layers; l++)
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(0, 99) < cfg_pct) push_cfg($urandom_range(0, N - 1));
                port_q[$urandom_range(0, N - 1)].push_back(mk(DATA, (base + l) % NSEQ, j, $urandom));
            end
    endtask

    initial begin
        rst = 1'b1; halt_force = 0; halt_pct = 0;
        in_valid = '0; in_packet = '0; SCH_MUL_halt = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Bias config, then a layer of three inputs with next-layer data queued behind/alongside.
        configure(0, 3, 32'd100);
        port_q[1].push_back(mk(DATA, 0, 0, 32'h11));
        port_q[2].push_back(mk(DATA, 0, 1, 32'h22));
        port_q[3].push_back(mk(DATA, 0, 2, 32'h33));
        port_q[0].push_back(mk(DATA, 1, 0, 32'h44));
        port_q[0].push_back(mk(DATA, 1, 1, 32'h55));
        port_q[2].push_back(mk(DATA, 1, 2, 32'h66));
        drain(100);

        // Downstream stall with a valid output and every port requesting.
        for (int i = 0; i < N; i++) begin push_cfg(i); push_cfg(i); end
        step();
        halt_force = 1;
        repeat (5) step();
        halt_force = 0;
        drain(100);

        for (int e = 0; e < 6; e++) begin
            halt_pct = $urandom_range(0, 50);
            configure($urandom_range(0, N - 1), $urandom_range(1, 5), $urandom);
            gen_layers(m_num, $urandom_range(2, 6), 30);
            drain(500);
        end

        // Single-input layers: exp_seq wraps through all sequence numbers.
        halt_pct = 20;
        configure(3, 1, 32'd7);
        gen_layers(1, NSEQ + 3, 10);
        drain(800);

        // source==0 returns to UNCONF: DATA for the current sequence is held until reconfigured.
        configure(0, 0, 32'd0);
        port_q[1].push_back(mk(DATA, m_exp, 0, 32'hABCD));
        repeat (8) step();
        port_q[2].push_back(mk(INB, 0, 1, 32'd5));
        drain(100);

`ifdef SCH_DROP_STALE_EN
        configure(0, 2, 32'd9);
        port_q[1].push_back(mk(DATA, (m_exp + NSEQ - 1) % NSEQ, 0, 32'hDEAD));
        drain(50);
        gen_layers(2, 2, 0);
        port_q[3].push_back(mk(DATA, (m_exp + NSEQ - 1) % NSEQ, 1, 32'hBEEF));
        drain(200);
`endif

        // Reset while the output register holds a stalled packet.
        push_cfg(2);
        step();
        halt_force = 1;
        repeat (2) step();
        halt_force = 0;
        do_reset();
        configure(1, 2, 32'd3);
        halt_pct = 30;
        gen_layers(2, 3, 20);
        drain(300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
